// File: rtl/div_seq_if.sv
// Divide handshake between the control unit (master) and the sequential
// divider (slave): operands and start request in, results and pulses out.
interface div_seq_if;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        div_init;
  logic        div_stop;
  logic        div_zero;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  modport master (
    output a_in,
    output b_in,
    output div_init,
    input  div_stop,
    input  div_zero,
    input  hi_out,
    input  lo_out
  );

  modport slave (
    input  a_in,
    input  b_in,
    input  div_init,
    output div_stop,
    output div_zero,
    output hi_out,
    output lo_out
  );
endinterface

// File: rtl/div_seq.sv
// div_seq: sequential signed 32-bit restoring divider for the multicycle CPU.
// Quotient goes to LO, remainder to HI; MIPS semantics (quotient truncates
// toward zero, remainder takes the dividend's sign). A zero divisor completes
// immediately with div_zero and leaves HI/LO untouched.
// Optional macro DIV_SEQ_FAST_EXIT_EN: when |a| < |b| the result is known at
// capture time (q = 0, r = a), so the 32 CALC steps are skipped.
module div_seq (
  input  logic clk,
  input  logic reset,
  div_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t      state;
  logic        sign_a;
  logic        sign_q;
  logic [31:0] mag_b_q;
  logic [32:0] rem;
  logic [31:0] quo;
  logic [4:0]  count;
  logic        div_stop_q;
  logic        div_zero_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [32:0] rem_shift;
  logic [31:0] quo_shift;
  logic [32:0] rem_next;
  logic [31:0] quo_next;
  logic [31:0] lo_final;
  logic [31:0] hi_final;

  // Operand magnitudes and one restoring step, plus the sign-corrected results
  always_comb begin
    mag_a     = bus.a_in[31] ? (32'd0 - bus.a_in) : bus.a_in;
    mag_b     = bus.b_in[31] ? (32'd0 - bus.b_in) : bus.b_in;
    rem_shift = {rem[31:0], quo[31]};
    quo_shift = {quo[30:0], 1'b0};
    rem_next  = rem_shift;
    quo_next  = quo_shift;
    if (rem[32] || (rem_shift >= {1'b0, mag_b_q})) begin
      rem_next = rem_shift - {1'b0, mag_b_q};
      quo_next = quo_shift | 32'd1;
    end
    lo_final = sign_q ? (32'd0 - quo_next) : quo_next;
    hi_final = sign_a ? (32'd0 - rem_next[31:0]) : rem_next[31:0];
  end

  // Control FSM with registered completion pulses and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      sign_a     <= 1'b0;
      sign_q     <= 1'b0;
      mag_b_q    <= 32'd0;
      rem        <= 33'd0;
      quo        <= 32'd0;
      count      <= 5'd0;
      div_stop_q <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          div_stop_q <= 1'b0;
          div_zero_q <= 1'b0;
          if (bus.div_init) begin
            sign_a  <= bus.a_in[31];
            sign_q  <= bus.a_in[31] ^ bus.b_in[31];
            mag_b_q <= mag_b;
            if (bus.b_in == 32'd0) begin
              div_stop_q <= 1'b1;
              div_zero_q <= 1'b1;
              state      <= FIN;
            end
`ifdef DIV_SEQ_FAST_EXIT_EN
            else if (mag_a < mag_b) begin
              lo_q       <= 32'd0;
              hi_q       <= bus.a_in;
              div_stop_q <= 1'b1;
              state      <= FIN;
            end
`endif
            else begin
              rem   <= 33'd0;
              quo   <= mag_a;
              count <= 5'd0;
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem   <= rem_next;
          quo   <= quo_next;
          count <= count + 5'd1;
          if (count == 5'd31) begin
            lo_q       <= lo_final;
            hi_q       <= hi_final;
            div_stop_q <= 1'b1;
            state      <= FIN;
          end
        end
        FIN: begin
          div_stop_q <= 1'b0;
          div_zero_q <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.div_stop = div_stop_q;
  assign bus.div_zero = div_zero_q;
  assign bus.hi_out   = hi_q;
  assign bus.lo_out   = lo_q;

endmodule

// File: tb/tb_div_seq.sv
// Testbench for div_seq: directed vectors with literal expectations, plus
// randomized divides checked against a plain-arithmetic reference model.
module tb_div_seq;

`ifdef DIV_SEQ_FAST_EXIT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic clk;
  logic reset;
  int   n_compared;
  int   n_mismatched;
  logic [31:0] model_hi;
  logic [31:0] model_lo;

  div_seq_if bus ();

  div_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        zero;
    logic        short_path;
  } vec_t;

  // Reference: signed 64-bit arithmetic truncates toward zero and gives the
  // remainder the dividend's sign; the low 32 bits give the wrapped result.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output int lat, output logic zero,
                                  output logic [31:0] hi, output logic [31:0] lo);
    longint sa, sb, q, r;
    if (b == 32'd0) begin
      zero = 1'b1;
      lat  = 1;
      hi   = model_hi;
      lo   = model_lo;
    end else begin
      sa   = longint'($signed(a));
      sb   = longint'($signed(b));
      q    = sa / sb;
      r    = sa % sb;
      lo   = q[31:0];
      hi   = r[31:0];
      zero = 1'b0;
      lat  = 33;
      if (FAST && ((sa < 0 ? -sa : sa) < (sb < 0 ? -sb : sb))) lat = 1;
      model_hi = hi;
      model_lo = lo;
    end
  endfunction

  // Launch one divide, scramble operands after capture, wait (bounded) for stop
  task automatic do_divide(input logic [31:0] a, input logic [31:0] b,
                           output int lat, output logic zero,
                           output logic [31:0] hi, output logic [31:0] lo,
                           output logic stop_after);
    @(negedge clk);
    bus.a_in = a;
    bus.b_in = b;
    bus.div_init = 1'b1;
    @(posedge clk);
    #1;
    bus.div_init = 1'b0;
    bus.a_in = $urandom;
    bus.b_in = $urandom;
    lat = -1;
    zero = 1'b0;
    hi = 32'd0;
    lo = 32'd0;
    stop_after = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.div_stop) begin
        lat = i;
        zero = bus.div_zero;
        hi = bus.hi_out;
        lo = bus.lo_out;
        break;
      end
    end
    if (lat > 0) begin
      @(negedge clk);
      stop_after = bus.div_stop;
    end
  endtask

  task automatic test_reset();
    int stops;
    bus.a_in = 32'd100;
    bus.b_in = 32'd7;
    bus.div_init = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_compared++;
    if ({bus.div_stop, bus.div_zero, bus.hi_out, bus.lo_out} !== 66'd0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_outputs: got stop=%b zero=%b hi=%h lo=%h, want all 0",
               bus.div_stop, bus.div_zero, bus.hi_out, bus.lo_out);
    end
    reset = 1'b0;
    bus.div_init = 1'b0;
    model_hi = 32'd0;
    model_lo = 32'd0;
    stops = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.div_stop) stops++;
    end
    n_compared++;
    if (stops !== 0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_no_start: got %0d stop pulses, want 0", stops);
    end
  endtask

  task automatic test_directed();
    vec_t tbl[11];
    int lat, exp_lat;
    logic zero, stop_after;
    logic [31:0] hi, lo;
    tbl = '{
      '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 1'b0},
      '{32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0, 1'b0},
      '{32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   32'd2,          1'b0, 1'b0},
      '{32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0, 1'b0},
      '{32'h80000000,   32'd1,          32'h80000000,   32'd0,          1'b0, 1'b0},
      '{32'd3,          32'd10,         32'd0,          32'd3,          1'b0, 1'b1},
      '{32'hFFFFFFFD,   32'd10,         32'd0,          32'hFFFFFFFD,   1'b0, 1'b1},
      '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 1'b0},
      '{32'd5,          32'd0,          32'd14,         32'd2,          1'b1, 1'b0},
      '{32'd7,          32'hFFFFFFF9,   32'hFFFFFFFF,   32'd0,          1'b0, 1'b0},
      '{32'd0,          32'd5,          32'd0,          32'd0,          1'b0, 1'b1}
    };
    foreach (tbl[k]) begin
      exp_lat = (tbl[k].zero || (FAST && tbl[k].short_path)) ? 1 : 33;
      do_divide(tbl[k].a, tbl[k].b, lat, zero, hi, lo, stop_after);
      n_compared++;
      if (lat !== exp_lat) begin
        n_mismatched++;
        $display("[TB] FAIL dir%0d_latency: got %0d, want %0d", k, lat, exp_lat);
      end
      n_compared++;
      if (zero !== tbl[k].zero) begin
        n_mismatched++;
        $display("[TB] FAIL dir%0d_zero: got %b, want %b", k, zero, tbl[k].zero);
      end
      n_compared++;
      if (lo !== tbl[k].lo) begin
        n_mismatched++;
        $display("[TB] FAIL dir%0d_lo: got %h, want %h", k, lo, tbl[k].lo);
      end
      n_compared++;
      if (hi !== tbl[k].hi) begin
        n_mismatched++;
        $display("[TB] FAIL dir%0d_hi: got %h, want %h", k, hi, tbl[k].hi);
      end
      n_compared++;
      if (stop_after !== 1'b0) begin
        n_mismatched++;
        $display("[TB] FAIL dir%0d_single_pulse: got stop=%b next cycle, want 0", k, stop_after);
      end
      if (!tbl[k].zero) begin
        model_lo = tbl[k].lo;
        model_hi = tbl[k].hi;
      end
    end
  endtask

  task automatic test_init_ignored();
    int lat;
    lat = -1;
    @(negedge clk);
    bus.a_in = 32'd100;
    bus.b_in = 32'd7;
    bus.div_init = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.div_stop) begin
        lat = i;
        break;
      end
      bus.div_init = (i == 10);
      if (i == 10) begin
        bus.a_in = 32'd9;
        bus.b_in = 32'd3;
      end
    end
    bus.div_init = 1'b0;
    n_compared++;
    if (lat !== 33) begin
      n_mismatched++;
      $display("[TB] FAIL ignored_init_latency: got %0d, want 33", lat);
    end
    n_compared++;
    if (bus.lo_out !== 32'd14 || bus.hi_out !== 32'd2) begin
      n_mismatched++;
      $display("[TB] FAIL ignored_init_result: got lo=%h hi=%h, want lo=0000000e hi=00000002",
               bus.lo_out, bus.hi_out);
    end
    model_lo = 32'd14;
    model_hi = 32'd2;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int stops;
    stops = 0;
    @(negedge clk);
    bus.a_in = 32'd100;
    bus.b_in = 32'd7;
    bus.div_init = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (bus.div_stop) stops++;
      if (i == 1) bus.div_init = 1'b0;
      if (i == 15) reset = 1'b1;
      if (i == 16) begin
        n_compared++;
        if ({bus.div_stop, bus.div_zero, bus.hi_out, bus.lo_out} !== 66'd0) begin
          n_mismatched++;
          $display("[TB] FAIL abort_outputs: got stop=%b zero=%b hi=%h lo=%h, want all 0",
                   bus.div_stop, bus.div_zero, bus.hi_out, bus.lo_out);
        end
        reset = 1'b0;
      end
    end
    n_compared++;
    if (stops !== 0) begin
      n_mismatched++;
      $display("[TB] FAIL abort_no_stop: got %0d stop pulses, want 0", stops);
    end
    model_hi = 32'd0;
    model_lo = 32'd0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] pa[3];
    logic [31:0] pb[3];
    logic [31:0] mag, exp_hi, exp_lo;
    logic exp_zero;
    int k, exp_lat;
    for (int j = 0; j < 3; j++) begin
      mag = 32'h40000000 | ($urandom & 32'h3FFFFFFF);
      pa[j] = ($urandom_range(0, 1) == 1) ? (32'd0 - mag) : mag;
      pb[j] = $urandom_range(1, 1000);
      if ($urandom_range(0, 1) == 1) pb[j] = 32'd0 - pb[j];
    end
    k = 0;
    @(negedge clk);
    bus.a_in = pa[0];
    bus.b_in = pb[0];
    bus.div_init = 1'b1;
    for (int i = 1; i <= 110; i++) begin
      @(negedge clk);
      if (bus.div_stop && k < 3) begin
        ref_div(pa[k], pb[k], exp_lat, exp_zero, exp_hi, exp_lo);
        n_compared++;
        if (i !== 33 + 34 * k) begin
          n_mismatched++;
          $display("[TB] FAIL b2b%0d_cycle: got %0d, want %0d", k, i, 33 + 34 * k);
        end
        n_compared++;
        if (bus.lo_out !== exp_lo || bus.hi_out !== exp_hi) begin
          n_mismatched++;
          $display("[TB] FAIL b2b%0d_result: got lo=%h hi=%h, want lo=%h hi=%h",
                   k, bus.lo_out, bus.hi_out, exp_lo, exp_hi);
        end
        k++;
        if (k < 3) begin
          bus.a_in = pa[k];
          bus.b_in = pb[k];
        end else begin
          bus.div_init = 1'b0;
        end
      end
    end
    bus.div_init = 1'b0;
    n_compared++;
    if (k !== 3) begin
      n_mismatched++;
      $display("[TB] FAIL b2b_count: got %0d completions, want 3", k);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, hi, lo, exp_hi, exp_lo;
    logic zero, exp_zero, stop_after;
    int lat, exp_lat;
    for (int n = 0; n < 25; n++) begin
      a = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h80000000;
      if ($urandom_range(0, 5) == 0) a = $urandom_range(0, 20);
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: b = 32'd0 - $urandom_range(1, 15);
        3: b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      ref_div(a, b, exp_lat, exp_zero, exp_hi, exp_lo);
      do_divide(a, b, lat, zero, hi, lo, stop_after);
      n_compared++;
      if (lat !== exp_lat || zero !== exp_zero || stop_after !== 1'b0) begin
        n_mismatched++;
        $display("[TB] FAIL rnd%0d_timing a=%h b=%h: got lat=%0d zero=%b again=%b, want lat=%0d zero=%b again=0",
                 n, a, b, lat, zero, stop_after, exp_lat, exp_zero);
      end
      n_compared++;
      if (lo !== exp_lo || hi !== exp_hi) begin
        n_mismatched++;
        $display("[TB] FAIL rnd%0d_result a=%h b=%h: got lo=%h hi=%h, want lo=%h hi=%h",
                 n, a, b, lo, hi, exp_lo, exp_hi);
      end
    end
  endtask

  // Hard stop in case anything above stalls
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_compared = 0;
    n_mismatched = 0;
    model_hi = 32'd0;
    model_lo = 32'd0;
    reset = 1'b0;
    bus.a_in = 32'd0;
    bus.b_in = 32'd0;
    bus.div_init = 1'b0;
    test_reset();
    test_directed();
    test_init_ignored();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
